// File: rtl/ram_pkg.sv
// Shared definitions for the sample-buffer read engine: default widths,
// read FSM state encoding and the output FIFO depth.
package ram_pkg;

  localparam int ADDR_WIDTH_DEF = 9;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int FIFO_DEPTH     = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } rd_state_t;

endpackage

// File: rtl/ram_reader_fifo.sv
// Four-entry first-word-fall-through FIFO with occupancy output; the head
// reads as zero while empty so the stream data is clean outside transfers.
module ram_reader_fifo
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int PTR_W      = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [PTR_W:0]        count,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wptr;
  logic [PTR_W-1:0]      rptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + {{(PTR_W-1){1'b0}}, 1'b1};
      if (pop)  rptr <= rptr + {{(PTR_W-1){1'b0}}, 1'b1};
      count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  assign empty = (count == '0);
  assign rdata = empty ? '0 : mem[rptr];

endmodule

// File: rtl/ram_reader.sv
// Streaming read engine over the sample buffer RAM with valid/ready output.
// Optional RAM_READER_STRIDE_EN adds a per-transfer address step input.
module ram_reader
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   count,
`ifdef RAM_READER_STRIDE_EN
  input  logic [ADDR_WIDTH-1:0] step,
`endif
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic [DATA_WIDTH-1:0] tdata,
  output logic                  tvalid,
  input  logic                  tready,
  output logic                  busy,
  output logic                  done
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_WIDTH:0] ONE_W   = (ADDR_WIDTH + 1)'(1);
  localparam logic [CNT_W:0]      DEPTH_L = (CNT_W + 1)'(FIFO_DEPTH);

  rd_state_t             state;
  logic [ADDR_WIDTH:0]   rem_rd;
  logic [ADDR_WIDTH:0]   rem_wr;
  logic [ADDR_WIDTH-1:0] step_r;
  logic                  vld_p0;
  logic                  vld_p1;
  logic                  zero_done;
  logic [CNT_W-1:0]      fifo_cnt;
  logic                  fifo_empty;
  logic [CNT_W:0]        occ;
  logic                  credit;
  logic                  accept;
  logic                  hs;

`ifdef RAM_READER_STRIDE_EN
  always_ff @(posedge clk) begin
    if (accept) step_r <= step;
  end
`else
  assign step_r = ADDR_WIDTH'(1);
`endif

  // Credit counts FIFO entries plus reads still travelling through the RAM.
  assign occ    = {1'b0, fifo_cnt} + {{CNT_W{1'b0}}, vld_p0} + {{CNT_W{1'b0}}, vld_p1};
  assign credit = (occ < DEPTH_L);
  assign accept = start && (state == IDLE) && !zero_done;
  assign tvalid = !fifo_empty;
  assign hs     = tvalid && tready;
  assign busy   = (state != IDLE) || zero_done;
  assign done   = zero_done || ((state == DRAIN) && hs && (rem_wr == ONE_W));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ram_raddr <= '0;
      rem_rd    <= '0;
      rem_wr    <= '0;
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      zero_done <= 1'b0;
    end else begin
      // p0: address registered; p1: RAM output registered; then FIFO write
      vld_p1    <= vld_p0;
      vld_p0    <= 1'b0;
      zero_done <= 1'b0;
      if (hs) rem_wr <= rem_wr - ONE_W;
      case (state)
        IDLE: begin
          if (accept) begin
            if (count == '0) begin
              zero_done <= 1'b1;
            end else begin
              state     <= READ;
              ram_raddr <= start_addr;
              vld_p0    <= 1'b1;
              rem_rd    <= count - ONE_W;
              rem_wr    <= count;
            end
          end
        end
        READ: begin
          if (rem_rd == '0) begin
            state <= DRAIN;
          end else if (credit) begin
            ram_raddr <= ram_raddr + step_r;
            vld_p0    <= 1'b1;
            rem_rd    <= rem_rd - ONE_W;
            if (rem_rd == ONE_W) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (hs && (rem_wr == ONE_W)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  ram_reader_fifo #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (vld_p1),
    .wdata(ram_dout),
    .pop  (hs),
    .rdata(tdata),
    .count(fifo_cnt),
    .empty(fifo_empty)
  );

endmodule

// File: tb/tb_ram_reader.sv
// Bench for ram_reader: RAM model with mem[a]=a[7:0], a transfer-level
// expected-word queue, and directed scenarios with literal expectations.
module tb_ram_reader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [8:0] start_addr = '0;
  logic [9:0] count = '0;
`ifdef RAM_READER_STRIDE_EN
  logic [8:0] step = 9'd1;
`endif
  logic [8:0] ram_raddr;
  logic [7:0] ram_dout = '0;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready = 1'b1;
  logic       busy;
  logic       done;

  logic [7:0] mem [512];

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q [$];
  logic [7:0] got_q [$];
  bit         model_busy = 0;
  bit         zero_pend  = 0;
  bit         clear_next = 0;
  bit         rst_edge   = 1;
  bit         prev_stall = 0;
  logic [7:0] prev_data  = '0;

  ram_reader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .start_addr(start_addr),
    .count     (count),
`ifdef RAM_READER_STRIDE_EN
    .step      (step),
`endif
    .ram_raddr (ram_raddr),
    .ram_dout  (ram_dout),
    .tdata     (tdata),
    .tvalid    (tvalid),
    .tready    (tready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ram_dout <= mem[ram_raddr];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Per-cycle compare, then advance the transfer model with the inputs that
  // the coming rising edge will sample.
  initial begin
    bit hs;
    bit exp_done;
    bit acc;
    int st;
    forever begin
      @(negedge clk);
      if (rst_edge) begin
        chk("rst_raddr", ram_raddr, 0);
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
      end else begin
        hs       = tvalid && tready;
        exp_done = zero_pend || (hs && exp_q.size() == 1);
        chk("done", done, exp_done);
        chk("busy", busy, model_busy);
        if (prev_stall) begin
          chk("hold_tvalid", tvalid, 1);
          chk("hold_tdata", tdata, prev_data);
        end
        if (exp_q.size() == 0) chk("spurious_tvalid", tvalid, 0);
        if (hs && exp_q.size() != 0) begin
          chk("tdata", tdata, exp_q[0]);
          got_q.push_back(tdata);
          void'(exp_q.pop_front());
        end
        prev_stall = tvalid && !tready;
        prev_data  = tdata;
        if (exp_done) clear_next = 1;
      end
      if (!rst_n) begin
        exp_q.delete();
        model_busy = 0;
        zero_pend  = 0;
        clear_next = 0;
        prev_stall = 0;
        rst_edge   = 1;
      end else begin
        rst_edge = 0;
        acc = start && !model_busy;
        if (clear_next) begin
          model_busy = 0;
          zero_pend  = 0;
          clear_next = 0;
        end
        if (acc) begin
          model_busy = 1;
`ifdef RAM_READER_STRIDE_EN
          st = int'(step);
`else
          st = 1;
`endif
          if (count == 0) zero_pend = 1;
          for (int i = 0; i < int'(count); i++)
            exp_q.push_back(mem[(int'(start_addr) + i * st) % 512]);
        end
      end
    end
  end

  task automatic go(input int addr, input int cnt);
    @(posedge clk); #1;
    start      = 1'b1;
    start_addr = 9'(addr);
    count      = 10'(cnt);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, input bit bp);
    bit ok;
    ok = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge clk); #1;
      if (bp) tready = (i % 4 == 0) || (i % 4 == 3);
      else    tready = 1'b1;
      if (!model_busy) begin
        ok = 1;
        break;
      end
    end
    chk("transfer_timeout", ok, 1);
    tready = 1'b1;
  endtask

  task automatic run_basic();
    got_q.delete();
    tready = 1'b1;
    go(10, 4);
    @(negedge clk);
    chk("first_raddr", ram_raddr, 10);
    chk("lat_tvalid_c1", tvalid, 0);
    @(negedge clk);
    chk("lat_tvalid_c2", tvalid, 0);
    @(negedge clk);
    chk("lat_tvalid_c3", tvalid, 1);
    chk("lat_tdata_c3", tdata, 10);
    wait_idle(20, 0);
    chk("basic_n", got_q.size(), 4);
    if (got_q.size() == 4) begin
      chk("basic_w0", got_q[0], 10);
      chk("basic_w1", got_q[1], 11);
      chk("basic_w2", got_q[2], 12);
      chk("basic_w3", got_q[3], 13);
    end
  endtask

  initial begin
    int a0;
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    for (int a = 0; a < 512; a++) mem[a] = 8'(a);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    run_basic();

    got_q.delete();
    go(510, 4);
    wait_idle(20, 0);
    chk("wrap_n", got_q.size(), 4);
    if (got_q.size() == 4) begin
      chk("wrap_w0", got_q[0], 8'hFE);
      chk("wrap_w1", got_q[1], 8'hFF);
      chk("wrap_w2", got_q[2], 8'h00);
      chk("wrap_w3", got_q[3], 8'h01);
    end

    got_q.delete();
    go(40, 8);
    wait_idle(100, 1);
    chk("bp_n", got_q.size(), 8);
    if (got_q.size() == 8)
      for (int i = 0; i < 8; i++) chk("bp_word", got_q[i], 40 + i);

    a0 = int'(ram_raddr);
    go(7, 0);
    @(negedge clk);
    chk("zero_done", done, 1);
    chk("zero_raddr", ram_raddr, a0);
    chk("zero_tvalid", tvalid, 0);
    wait_idle(10, 0);

    got_q.delete();
    go(100, 512);
    wait_idle(700, 0);
    chk("full_n", got_q.size(), 512);
    if (got_q.size() == 512) begin
      chk("full_first", got_q[0], 100);
      chk("full_wrap", got_q[412], 0);
      chk("full_last", got_q[511], 99);
    end

    got_q.delete();
    go(20, 6);
    @(posedge clk); #1;
    start = 1'b1; start_addr = 9'd100; count = 10'd5;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle(40, 0);
    repeat (5) @(posedge clk);
    chk("busy_start_n", got_q.size(), 6);
    if (got_q.size() == 6) chk("busy_start_last", got_q[5], 25);

    go(30, 8);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("post_rst_tvalid", tvalid, 0);
    run_basic();

`ifdef RAM_READER_STRIDE_EN
    got_q.delete();
    step = 9'd3;
    go(508, 3);
    wait_idle(20, 0);
    step = 9'd1;
    chk("stride_n", got_q.size(), 3);
    if (got_q.size() == 3) begin
      chk("stride_w0", got_q[0], 8'hFC);
      chk("stride_w1", got_q[1], 8'hFF);
      chk("stride_w2", got_q[2], 8'h02);
    end
`endif

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
